// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared state type, wait-counter width and address decode for wb_slave_regbank.
package wb_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} wb_slv_state_t;

  localparam int WCNT_W = 4;

  // Mapped = one of the RW registers or the RO counter at the top word address.
  function automatic logic is_mapped(input int adr, input int num_regs, input int addr_w);
    return (adr < num_regs) || (adr == (1 << addr_w) - 1);
  endfunction

endpackage

// File: rtl/wb_slave_wait_ctr.sv
// rtl/wb_slave_wait_ctr.sv - loadable down-counter with zero flag, pacing wait states before ack.
module wb_slave_wait_ctr
  import wb_slave_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WCNT_W-1:0] load_val_i,
  input  logic              en_i,
  output logic [WCNT_W-1:0] count_o,
  output logic              zero_o
);

  logic [WCNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/wb_slave_regbank.sv
// rtl/wb_slave_regbank.sv - Wishbone classic slave: RW register bank, RO transfer counter, wait states.
// Define WB_SLV_ERR_EN to terminate unmapped accesses and counter writes with wb_err_o.
module wb_slave_regbank
  import wb_slave_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [ADDR_W-1:0]          wb_adr_i,
  input  logic [DATA_W-1:0]          wb_dat_i,
  output logic [DATA_W-1:0]          wb_dat_o,
  input  logic                       wb_we_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_cyc_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam logic [ADDR_W-1:0] CNT_ADR = '1;

  wb_slv_state_t     state_q, state_d;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              req, resp, bad, ack;
  logic              wcnt_load, wcnt_zero;
  logic [WCNT_W-1:0] wcnt;
  logic [DATA_W-1:0] rdata;

  assign req       = wb_cyc_i & wb_stb_i;
  assign wcnt_load = (state_q == IDLE) & req;

  wb_slave_wait_ctr u_wait_ctr (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (wcnt_load),
    .load_val_i (WCNT_W'(WAIT_STATES)),
    .en_i       (state_q == WAIT),
    .count_o    (wcnt),
    .zero_o     (wcnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if ((wcnt == WCNT_W'(1)) || wcnt_zero) begin
          state_d = RESP;
        end
      end
      RESP: state_d = HOLD;
      // Stay until the master drops req so one transfer never gets two acks.
      HOLD: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_SLV_ERR_EN
  assign bad = !is_mapped(int'(adr_q), NUM_REGS, ADDR_W) || (we_q && (adr_q == CNT_ADR));
`else
  assign bad = 1'b0;
`endif

  assign resp = (state_q == RESP);
  assign ack  = resp & ~bad;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (adr_q == ADDR_W'(k)) rdata = regs_q[k];
    end
    if (adr_q == CNT_ADR) rdata = cnt_q;
  end

  assign wb_ack_o = ack;
  assign wb_err_o = resp & bad;
  assign wb_dat_o = ack ? rdata : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (wcnt_load) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i;
      end
      if (ack) begin
        cnt_q <= cnt_q + DATA_W'(1);
        for (int k = 0; k < NUM_REGS; k++) begin
          if (we_q && (adr_q == ADDR_W'(k))) regs_q[k] <= dat_q;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
